// File: rtl/sample_packer_pkg.sv
// Shared definitions for the sample packer: default geometry, FSM states and
// the lane-counter width helper.
package sample_packer_pkg;

    localparam int SAMPLE_W_DEF = 21;
    localparam int LANES_DEF    = 8;
    localparam int WIDTH_DEF    = SAMPLE_W_DEF * LANES_DEF;

    typedef enum logic [0:0] {
        SEEK = 1'b0,
        FILL = 1'b1
    } pack_state_e;

    // A single-lane packer still needs a one-bit counter port.
    function automatic int lane_cnt_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/sample_packer.sv
// Packs signed samples into LANES-wide words aligned to start-of-frame.
// Optional macro SAMPLE_PACKER_ZPAD_EN: a mid-word i_sof flushes the partial
// word zero-padded instead of dropping it.
module sample_packer
    import sample_packer_pkg::*;
#(
    parameter int  SAMPLE_W = SAMPLE_W_DEF,
    parameter int  LANES    = LANES_DEF,
    parameter int  SYNC_REQ = 1,
    localparam int WIDTH    = SAMPLE_W * LANES,
    localparam int CNT_W    = lane_cnt_w(LANES)
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_valid,
    input  logic                       i_sof,
    input  logic signed [SAMPLE_W-1:0] i_data,
    output logic                       o_valid,
    output logic        [WIDTH-1:0]    o_data,
    output logic        [CNT_W-1:0]    o_lane_cnt,
    output logic                       o_drop
);

    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);
    localparam pack_state_e      RST_STATE = (SYNC_REQ != 0) ? SEEK : FILL;

    pack_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             drop_q, drop_d;

    logic [CNT_W-1:0] wr_lane_s;
    logic [WIDTH-1:0] word_s;
    logic             accept_s;
    logic             restart_s;

    // Next-state logic: lane write decode, word emission and frame realignment.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        drop_d    = 1'b0;
        accept_s  = i_valid && ((state_q == FILL) || i_sof);
        restart_s = i_valid && i_sof && (state_q == FILL) && (cnt_q != '0);
        wr_lane_s = (state_q == SEEK) ? '0 : cnt_q;

        word_s = buf_q;
        for (int k = 0; k < LANES; k++) begin
            if (wr_lane_s == CNT_W'(k)) begin
                word_s[k*SAMPLE_W +: SAMPLE_W] = i_data;
            end else begin
                word_s[k*SAMPLE_W +: SAMPLE_W] = buf_q[k*SAMPLE_W +: SAMPLE_W];
            end
        end

        if (restart_s) begin
`ifdef SAMPLE_PACKER_ZPAD_EN
            // Unfilled lanes of buf_q are already zero, so it is the padded word.
            data_d  = buf_q;
            valid_d = 1'b1;
`else
            drop_d  = 1'b1;
`endif
            buf_d                = '0;
            buf_d[SAMPLE_W-1:0]  = i_data;
            cnt_d                = CNT_W'(1);
        end else if (accept_s) begin
            state_d = FILL;
            if (wr_lane_s == LAST_LANE) begin
                data_d  = word_s;
                valid_d = 1'b1;
                buf_d   = '0;
                cnt_d   = '0;
            end else begin
                buf_d = word_s;
                cnt_d = wr_lane_s + CNT_W'(1);
            end
        end else begin
            state_d = state_q;
        end
    end

    // State, assembly buffer and registered outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            buf_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_lane_cnt = cnt_q;
    assign o_drop     = drop_q;

endmodule

// File: tb/tb_sample_packer.sv
// Directed self-checking bench for sample_packer at default parameters.
module tb_sample_packer;

    localparam int SW = 21;
    localparam int NL = 8;
    localparam int W  = SW * NL;

    logic          clk = 1'b0;
    logic          rst;
    logic          vld;
    logic          sof;
    logic [SW-1:0] din;
    logic          o_valid;
    logic [W-1:0]  o_data;
    logic [2:0]    o_lane_cnt;
    logic          o_drop;

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;
    int dcnt   = 0;

    always #5 clk = ~clk;

    sample_packer dut (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_valid   (vld),
        .i_sof     (sof),
        .i_data    (din),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .o_lane_cnt(o_lane_cnt),
        .o_drop    (o_drop)
    );

    function automatic logic [W-1:0] seq_word(input int first, input int inc, input int n);
        logic [W-1:0] w;
        int           v;
        w = '0;
        for (int k = 0; k < n; k++) begin
            v = first + k * inc;
            w[k*SW +: SW] = v[SW-1:0];
        end
        return w;
    endfunction

    task automatic send(input logic v, input logic s, input int d);
        vld = v;
        sof = s;
        din = d[SW-1:0];
        @(posedge clk);
        #1;
        if (o_valid) vcnt++;
        if (o_drop) dcnt++;
    endtask

    task automatic send_seq(input int first, input int inc, input int n, input logic s0, input logic gap);
        for (int k = 0; k < n; k++) begin
            send(1'b1, (k == 0) ? s0 : 1'b0, first + k * inc);
            if (gap) send(1'b0, 1'b1, 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        send(1'b0, 1'b0, 0);
        rst = 1'b0;
        vcnt = 0;
        dcnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        send(1'b1, 1'b1, 5);
        send(1'b1, 1'b1, 6);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        checks++; if (o_drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b expected 0", o_drop); end
        checks++; if (o_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", o_data); end
        checks++; if (o_lane_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", o_lane_cnt); end
        rst = 1'b0;
        send(1'b0, 1'b0, 0);
        vcnt = 0;
        dcnt = 0;
    endtask

    task automatic test_basic();
        for (int k = 1; k <= 8; k++) begin
            send(1'b1, k == 1, k);
            if (k == 3) begin
                checks++; if (o_lane_cnt !== 3'd3) begin errors++; $display("FAIL basic_midcnt: got %0d expected 3", o_lane_cnt); end
            end
            if (k < 8) begin
                checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0 at sample %0d", o_valid, k); end
            end
        end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", o_valid); end
        checks++; if (o_data !== seq_word(1, 1, 8)) begin errors++; $display("FAIL basic_data: got %h expected %h", o_data, seq_word(1, 1, 8)); end
        checks++; if (o_lane_cnt !== 3'd0) begin errors++; $display("FAIL basic_cnt: got %0d expected 0", o_lane_cnt); end
        send(1'b0, 1'b0, 0);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_len: got %b expected 0", o_valid); end
        checks++; if (o_data !== seq_word(1, 1, 8)) begin errors++; $display("FAIL basic_hold: got %h expected %h", o_data, seq_word(1, 1, 8)); end
    endtask

    task automatic test_extremes();
        logic [W-1:0] ones;
        logic [W-1:0] msb;
        ones = '1;
        msb  = '0;
        for (int k = 0; k < NL; k++) msb[k*SW + SW - 1] = 1'b1;
        send_seq(-1, 0, 8, 1'b1, 1'b0);
        checks++; if (o_valid !== 1'b1 || o_data !== ones) begin errors++; $display("FAIL ext_ones: got v=%b %h expected v=1 %h", o_valid, o_data, ones); end
        send_seq(-1048576, 0, 8, 1'b0, 1'b0);
        checks++; if (o_valid !== 1'b1 || o_data !== msb) begin errors++; $display("FAIL ext_minneg: got v=%b %h expected v=1 %h", o_valid, o_data, msb); end
    endtask

    task automatic test_gaps();
        vcnt = 0;
        send_seq(1, 1, 8, 1'b1, 1'b1);
        checks++; if (vcnt !== 1) begin errors++; $display("FAIL gap_pulses: got %0d expected 1", vcnt); end
        for (int k = 0; k < 4; k++) send(1'b0, 1'b0, 0);
        checks++; if (o_data !== seq_word(1, 1, 8)) begin errors++; $display("FAIL gap_data: got %h expected %h", o_data, seq_word(1, 1, 8)); end
        checks++; if (vcnt !== 1) begin errors++; $display("FAIL gap_extra_pulse: got %0d expected 1", vcnt); end
    endtask

    task automatic test_seek();
        do_reset();
        send_seq(9, 0, 3, 1'b0, 1'b0);
        checks++; if (o_lane_cnt !== 3'd0) begin errors++; $display("FAIL seek_discard_cnt: got %0d expected 0", o_lane_cnt); end
        send_seq(1, 1, 8, 1'b1, 1'b0);
        checks++; if (o_valid !== 1'b1 || o_data !== seq_word(1, 1, 8)) begin errors++; $display("FAIL seek_word: got v=%b %h expected v=1 %h", o_valid, o_data, seq_word(1, 1, 8)); end
        checks++; if (dcnt !== 0) begin errors++; $display("FAIL seek_drop: got %0d expected 0", dcnt); end
    endtask

    task automatic test_sof_midword();
        do_reset();
        send_seq(1, 1, 3, 1'b1, 1'b0);
        send(1'b1, 1'b1, 10);
`ifdef SAMPLE_PACKER_ZPAD_EN
        checks++; if (o_valid !== 1'b1 || o_data !== seq_word(1, 1, 3)) begin errors++; $display("FAIL zpad_word: got v=%b %h expected v=1 %h", o_valid, o_data, seq_word(1, 1, 3)); end
        checks++; if (o_drop !== 1'b0) begin errors++; $display("FAIL zpad_drop: got %b expected 0", o_drop); end
`else
        checks++; if (o_drop !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL midsof_drop: got drop=%b v=%b expected drop=1 v=0", o_drop, o_valid); end
`endif
        checks++; if (o_lane_cnt !== 3'd1) begin errors++; $display("FAIL midsof_cnt: got %0d expected 1", o_lane_cnt); end
        send_seq(11, 1, 7, 1'b0, 1'b0);
        checks++; if (o_valid !== 1'b1 || o_data !== seq_word(10, 1, 8)) begin errors++; $display("FAIL midsof_next: got v=%b %h expected v=1 %h", o_valid, o_data, seq_word(10, 1, 8)); end
    endtask

    task automatic test_reset_midword();
        send_seq(1, 1, 5, 1'b1, 1'b0);
        rst = 1'b1;
        send(1'b1, 1'b0, 6);
        rst = 1'b0;
        vcnt = 0;
        dcnt = 0;
        checks++; if (o_data !== '0 || o_lane_cnt !== 3'd0) begin errors++; $display("FAIL rstmid_clear: got %h cnt=%0d expected 0 cnt=0", o_data, o_lane_cnt); end
        send_seq(1, 1, 7, 1'b1, 1'b0);
        checks++; if (vcnt !== 0 || dcnt !== 0 || o_data !== '0) begin errors++; $display("FAIL rstmid_quiet: got v=%0d d=%0d %h expected 0 0 0", vcnt, dcnt, o_data); end
        send(1'b1, 1'b0, 8);
        checks++; if (o_valid !== 1'b1 || o_data !== seq_word(1, 1, 8)) begin errors++; $display("FAIL rstmid_word: got v=%b %h expected v=1 %h", o_valid, o_data, seq_word(1, 1, 8)); end
    endtask

    task automatic test_back_to_back();
        send_seq(1, 1, 8, 1'b1, 1'b0);
        send(1'b1, 1'b1, 11);
        checks++; if (o_valid !== 1'b0 || o_lane_cnt !== 3'd1 || o_drop !== 1'b0) begin errors++; $display("FAIL b2b_start: got v=%b cnt=%0d d=%b expected 0 1 0", o_valid, o_lane_cnt, o_drop); end
        checks++; if (o_data !== seq_word(1, 1, 8)) begin errors++; $display("FAIL b2b_hold: got %h expected %h", o_data, seq_word(1, 1, 8)); end
        send_seq(12, 1, 7, 1'b0, 1'b0);
        checks++; if (o_valid !== 1'b1 || o_data !== seq_word(11, 1, 8)) begin errors++; $display("FAIL b2b_word: got v=%b %h expected v=1 %h", o_valid, o_data, seq_word(11, 1, 8)); end
    endtask

    initial begin
        rst = 1'b0;
        vld = 1'b0;
        sof = 1'b0;
        din = '0;
        test_reset();
        test_basic();
        test_extremes();
        test_gaps();
        test_seek();
        test_sof_midword();
        test_reset_midword();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
